// File: rtl/channel_serializer.sv
// Four-channel frame serializer: buffers up to two sample frames and emits them as AXI-Stream beats.
// Optional drop counter output enabled by defining CHANNEL_SERIALIZER_DROP_CNT_EN.
//
//   state | meaning
//   IDLE  | frame buffer empty, no beat offered
//   SEND  | at least one frame buffered, beat ch of head frame offered
module channel_serializer #(
  parameter int DATA_W = 24,
  parameter int OUT_W  = 32
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_ch0,
  input  logic signed [DATA_W-1:0] in_ch1,
  input  logic signed [DATA_W-1:0] in_ch2,
  input  logic signed [DATA_W-1:0] in_ch3,
  output logic [OUT_W-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [1:0]               m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef CHANNEL_SERIALIZER_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] frame_mem [2][4];
  logic                     wr_ptr, rd_ptr;
  logic [1:0]               count, count_next;
  logic [1:0]               ch;
  logic                     hs, pop, accept, drop;
  logic signed [DATA_W-1:0] cur_sample;

  assign hs     = m_axis_tvalid & m_axis_tready;
  assign pop    = hs & (ch == 2'd3);
  assign accept = in_valid & ((count != 2'd2) | pop);
  assign drop   = in_valid & (count == 2'd2) & ~pop;

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next    = state;
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (count_next != 2'd0) state_next = SEND;
      end
      SEND: begin
        m_axis_tvalid = 1'b1;
        if (pop && count_next == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      ch     <= 2'd0;
    end else begin
      count <= count_next;
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      if (hs)     ch     <= ch + 2'd1;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge s_axis_aclk) begin
    if (accept && !s_axis_arst) begin
      frame_mem[wr_ptr][0] <= in_ch0;
      frame_mem[wr_ptr][1] <= in_ch1;
      frame_mem[wr_ptr][2] <= in_ch2;
      frame_mem[wr_ptr][3] <= in_ch3;
    end
  end

  assign cur_sample   = frame_mem[rd_ptr][ch];
  assign m_axis_tdata = OUT_W'(cur_sample);
  assign m_axis_tuser = ch;
  assign m_axis_tlast = m_axis_tvalid & (ch == 2'd3);

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst)  ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef CHANNEL_SERIALIZER_DROP_CNT_EN
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      drop_cnt <= 16'd0;
    end else if (drop) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (ovf_clr) begin
      drop_cnt <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_channel_serializer.sv
// Self-checking bench for channel_serializer: frame-queue model, per-cycle compare, directed and random stimulus.
module tb_channel_serializer;
  localparam int DW = 24;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_ch0, in_ch1, in_ch2, in_ch3;
  logic [OW-1:0] tdata;
  logic          tvalid, tready, tlast, ovf, ovf_clr;
  logic [1:0]    tuser;
`ifdef CHANNEL_SERIALIZER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  channel_serializer #(.DATA_W(DW), .OUT_W(OW)) dut (
    .s_axis_aclk(clk), .s_axis_arst(rst), .in_valid(in_valid),
    .in_ch0(in_ch0), .in_ch1(in_ch1), .in_ch2(in_ch2), .in_ch3(in_ch3),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef CHANNEL_SERIALIZER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [OW-1:0] sext(input logic [4*DW-1:0] f, input int c);
    logic signed [DW-1:0] s;
    s = f[c*DW +: DW];
    return OW'(s);
  endfunction

  // Model: queue of whole frames, beat index into head frame, sticky flag, drop count.
  logic [4*DW-1:0] q[$];
  int  beat;
  bit  movf;
  int  mdcnt;
  bit  started = 0;

  always @(posedge clk) begin
    bit hs, pop, drop;
    if (rst) begin
      q.delete();
      beat    = 0;
      movf    = 0;
      mdcnt   = 0;
      started = 1;
    end else if (started) begin
      hs   = (q.size() > 0) && tready;
      pop  = hs && (beat == 3);
      drop = in_valid && (q.size() == 2) && !pop;
      if (hs) beat = (beat + 1) % 4;
      if (pop) void'(q.pop_front());
      if (in_valid && !drop) q.push_back({in_ch3, in_ch2, in_ch1, in_ch0});
      if (drop) begin
        movf = 1;
        if (mdcnt < 16'hFFFF) mdcnt++;
      end else if (ovf_clr) begin
        movf  = 0;
        mdcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("tvalid", tvalid, q.size() > 0);
      chk("tuser", tuser, beat[1:0]);
      chk("tlast", tlast, (q.size() > 0) && (beat == 3));
      if (q.size() > 0) chk("tdata", tdata, sext(q[0], beat));
      chk("ovf", ovf, movf);
`ifdef CHANNEL_SERIALIZER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, mdcnt[15:0]);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] a, b, c, d);
    in_ch0 = a; in_ch1 = b; in_ch2 = c; in_ch3 = d;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic chk_dcnt(input string nm, input int exp);
`ifdef CHANNEL_SERIALIZER_DROP_CNT_EN
    chk(nm, drop_cnt, exp[15:0]);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; tready = 1'b0; ovf_clr = 1'b0;
    in_ch0 = '0; in_ch1 = '0; in_ch2 = '0; in_ch3 = '0;

    // Single frame with sign-extension corners
    do_reset();
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_tlast", tlast, 1'b0);
    chk("reset_tuser", tuser, 2'd0);
    chk("reset_ovf", ovf, 1'b0);
    tready = 1'b1;
    put(24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000);
    step(); in_valid = 1'b0;
    chk("b0_tvalid", tvalid, 1'b1);
    chk("b0_tdata", tdata, 32'h00000001);
    chk("b0_tuser", tuser, 2'd0);
    chk("b0_tlast", tlast, 1'b0);
    step();
    chk("b1_tdata", tdata, 32'hFFFFFFFF);
    chk("b1_tuser", tuser, 2'd1);
    step();
    chk("b2_tdata", tdata, 32'h007FFFFF);
    chk("b2_tuser", tuser, 2'd2);
    step();
    chk("b3_tdata", tdata, 32'hFF800000);
    chk("b3_tlast", tlast, 1'b1);
    step();
    chk("after_frame_tvalid", tvalid, 1'b0);

    // Backpressure mid-frame at ch=1
    do_reset();
    tready = 1'b1;
    put(24'h11, 24'h22, 24'h33, 24'h44);
    step(); in_valid = 1'b0;
    step();
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_tuser", tuser, 2'd1);
      chk("stall_tdata", tdata, 32'h22);
    end
    tready = 1'b1;
    step();
    chk("resume_tuser", tuser, 2'd2);
    chk("resume_tdata", tdata, 32'h33);
    step();
    chk("resume_last", tdata, 32'h44);
    step();

    // Overflow: third frame dropped, first two intact in order
    do_reset();
    tready = 1'b0;
    put(24'd1, 24'd2, 24'd3, 24'd4); step();
    put(24'd5, 24'd6, 24'd7, 24'd8); step();
    put(24'd9, 24'd10, 24'd11, 24'd12); step();
    in_valid = 1'b0;
    step();
    chk("ovf_set", ovf, 1'b1);
    chk_dcnt("dcnt_one", 1);
    tready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_order", tdata, 32'(k));
      step();
    end
    chk("ovf_drained", tvalid, 1'b0);

    // Accept coincident with the channel-3 handshake while full
    do_reset();
    tready = 1'b0;
    put(24'h100, 24'h101, 24'h102, 24'h103); step();
    put(24'h200, 24'h201, 24'h202, 24'h203); step();
    in_valid = 1'b0;
    tready = 1'b1;
    step(); step(); step();
    chk("full_at_ch3", tuser, 2'd3);
    put(24'h300, 24'h301, 24'h302, 24'h303);
    step(); in_valid = 1'b0;
    chk("swap_ovf", ovf, 1'b0);
    chk("swap_tuser", tuser, 2'd0);
    chk("swap_tdata", tdata, 32'h200);
    step(); step(); step(); step();
    chk("swap_new_frame", tdata, 32'h300);

    // Reset in mid-frame with two frames buffered and ovf set
    do_reset();
    tready = 1'b0;
    put(24'h400, 24'h401, 24'h402, 24'h403); step();
    put(24'h410, 24'h411, 24'h412, 24'h413); step();
    put(24'h420, 24'h421, 24'h422, 24'h423); step();
    in_valid = 1'b0;
    tready = 1'b1;
    step(); step();
    chk("pre_rst_tuser", tuser, 2'd2);
    chk("pre_rst_ovf", ovf, 1'b1);
    rst = 1'b1;
    put(24'h4F0, 24'h4F1, 24'h4F2, 24'h4F3);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    step();
    chk("rst_ignored_frame", tvalid, 1'b0);
    put(24'h500, 24'h501, 24'h502, 24'h503);
    step(); in_valid = 1'b0;
    chk("post_rst_tvalid", tvalid, 1'b1);
    chk("post_rst_tuser", tuser, 2'd0);
    chk("post_rst_tdata", tdata, 32'h500);
    step(); step(); step(); step();

    // Clear coincident with a drop, then clear alone
    do_reset();
    tready = 1'b0;
    put(24'd1, 24'd1, 24'd1, 24'd1); step();
    put(24'd2, 24'd2, 24'd2, 24'd2); step();
    put(24'd3, 24'd3, 24'd3, 24'd3); ovf_clr = 1'b1; step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("clr_drop_ovf", ovf, 1'b1);
    chk_dcnt("clr_drop_dcnt", 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr_ovf", ovf, 1'b0);
    chk_dcnt("clr_dcnt", 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      tready   = ($urandom_range(0, 99) < 65);
      ovf_clr  = ($urandom_range(0, 99) < 3);
      in_valid = ($urandom_range(0, 99) < 30);
      in_ch0 = DW'($urandom); in_ch1 = DW'($urandom);
      in_ch2 = DW'($urandom); in_ch3 = DW'($urandom);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; ovf_clr = 1'b0; tready = 1'b1;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/channel_serializer.md
CHANNEL_SERIALIZER -- requirements
Module: channel_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the input sample width (signed).
REQ-002 SHALL have parameter OUT_W, default 32, meaning the m_axis_tdata width; OUT_W >= DATA_W.
REQ-003 SHALL have port s_axis_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port s_axis_arst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, a one-cycle strobe marking a simultaneous 4-channel sample frame.
REQ-006 SHALL have ports in_ch0..in_ch3, input, DATA_W each, signed samples for channels 0..3, sampled when in_valid=1.
REQ-007 SHALL have port m_axis_tdata, output, OUT_W, the sign-extended sample of the current channel.
REQ-008 SHALL have port m_axis_tvalid, output, 1, the AXI-Stream valid.
REQ-009 SHALL have port m_axis_tready, input, 1, the AXI-Stream ready from the downstream filter.
REQ-010 SHALL have port m_axis_tuser, output, 2, the channel index of the current beat.
REQ-011 SHALL have port m_axis_tlast, output, 1, high on the channel-3 beat.
REQ-012 SHALL have port ovf, output, 1, a sticky flag meaning at least one frame was dropped.
REQ-013 SHALL have port ovf_clr, input, 1, a one-cycle pulse that clears ovf.

Function
REQ-014 SHALL store frames in a 2-entry frame buffer (wr_ptr, rd_ptr, count 0..2); each entry holds all four samples.
REQ-015 SHALL write in_ch0..3 into the entry at wr_ptr when in_valid=1 and (count<2 or a frame pop occurs in the same cycle).
REQ-016 SHALL drop the frame and set ovf when in_valid=1, count==2 and no pop occurs in that cycle; buffer contents are untouched.
REQ-017 SHALL implement FSM IDLE/SEND: IDLE->SEND when count becomes nonzero; SEND->IDLE on the channel-3 handshake when count becomes 0; otherwise remain in SEND.
REQ-018 SHALL drive m_axis_tvalid=1 exactly when in SEND (count>0), so the first beat appears one cycle after the accepting in_valid.
REQ-019 SHALL drive m_axis_tdata = sign-extend(entry[rd_ptr][ch]) and m_axis_tuser = ch, where ch is a 2-bit beat counter.
REQ-020 SHALL hold tdata, tuser and tlast stable while tvalid=1 and tready=0.
REQ-021 SHALL increment ch on each handshake (tvalid&tready); a handshake at ch=3 wraps ch to 0, advances rd_ptr and decrements count (pop).
REQ-022 SHALL keep count unchanged on a simultaneous accept and pop; wr_ptr and rd_ptr both advance, mod 2.
REQ-023 SHALL emit back-to-back frames with no idle cycle when count>1 and tready is held high (4 beats per 4 cycles).
REQ-024 SHALL resolve ovf as follows: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
REQ-025 SHALL never emit a partial frame; tuser always runs 0,1,2,3 per frame.

Reset
REQ-026 SHALL, while s_axis_arst=1, force m_axis_tvalid=0, tlast=0, tuser=0, ch=0, count=0, wr_ptr=rd_ptr=0, ovf=0, and FSM=IDLE.
REQ-027 SHALL discard any frame in progress or buffered on reset; an in_valid coincident with reset is ignored.
REQ-028 SHALL allow m_axis_tdata to be undefined after reset until the first accepted frame; the buffer has no reset.

Configuration
REQ-029 SHALL, with CHANNEL_SERIALIZER_DROP_CNT_EN defined, add output drop_cnt (16 bits), reset to 0, incremented on each dropped frame, saturating at 0xFFFF, and cleared by ovf_clr (increment wins when simultaneous).
REQ-030 SHALL, without CHANNEL_SERIALIZER_DROP_CNT_EN, omit drop_cnt and its logic, leaving all other behaviour identical.

Verification
REQ-031 Single frame (0x000001, 0xFFFFFF, 0x7FFFFF, 0x800000) with tready=1 -> beats tdata 0x00000001, 0xFFFFFFFF, 0x007FFFFF, 0xFF800000; tuser 0..3; tlast only on beat 4; first beat one cycle after in_valid.
REQ-032 tready=0 for 5 cycles mid-frame at ch=1 -> tdata/tuser held, then resumes at ch=1 with no beat lost or repeated.
REQ-033 tready=0 and 3 frames strobed -> frames 1-2 output intact in order, frame 3 dropped, ovf=1, drop_cnt=1 (macro on).
REQ-034 count==2 with in_valid coincident with the channel-3 handshake -> new frame accepted, ovf stays 0.
REQ-035 Reset asserted at ch=2 with count=2 -> next cycle tvalid=0, ovf=0; next frame starts at tuser=0.
REQ-036 ovf_clr coincident with a drop -> ovf remains 1; ovf_clr alone the next cycle -> ovf=0, drop_cnt=0.
